// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetch queue between imem and IF/ID.
// Latency: imem response to inst_valid_o is 1 cycle (0 cycles with FQ_BYPASS_EN on an empty queue).
// Backpressure: requests issue only while occ + osd < DEPTH, so every response already has a reserved slot.
//
// Ports:
//   clk, rst (async, active-low)
//   redirect_i / redirect_pc_i          taken branch/jump; flushes the queue
//   imem_req_o / imem_addr_o / imem_gnt_i               request channel
//   imem_rvalid_i / imem_rdata_i                         in-order responses
//   inst_valid_o / inst_o / pc_plus4_o / inst_ready_i   decode side
// Optional feature: define FQ_BYPASS_EN to forward a response straight to the
// outputs when the queue is empty and nothing is being discarded.

// Small ring buffer. Occupancy is tracked by the owner, which never pushes
// into a full buffer or pops an empty one.
module fq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset; the owner never presents an unwritten slot as valid.
    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_plus4_o,
    input  logic        inst_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] occ;      // buffered entries
    logic [CW-1:0] osd;      // requests granted, response not yet seen
    logic [CW-1:0] dsc;      // outstanding responses still to be thrown away
    logic [CW:0]   credit_sum;

    logic          issue;
    logic          resp_keep;
    logic          push_vld;
    logic          pop_vld;
    logic          fifo_vld;
    logic          byp_vld;
    logic          byp_take;
    logic [31:0]   tag_pc;
    logic [31:0]   resp_pc4;
    logic [63:0]   head_dat;
    logic [63:0]   last_dat;

    // Credit covers both buffered and in-flight entries, so a response can always land.
    assign credit_sum  = {1'b0, occ} + {1'b0, osd};
    assign imem_req_o  = !redirect_i && (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;

    // PC of every outstanding request, in issue order. Never flushed: stale
    // responses still arrive and must pop their tag.
    fq_fifo #(.W(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push_vld (issue),
        .push_dat (fetch_pc),
        .pop_vld  (imem_rvalid_i),
        .head_dat (tag_pc)
    );

    assign resp_pc4  = tag_pc + 32'd4;
    // A response arriving alongside a redirect belongs to the old path.
    assign resp_keep = imem_rvalid_i && (dsc == '0) && !redirect_i;
    assign fifo_vld  = (occ != '0);

`ifdef FQ_BYPASS_EN
    assign byp_vld  = resp_keep && (occ == '0);
    assign byp_take = byp_vld && inst_ready_i;
`else
    assign byp_vld  = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign push_vld = resp_keep && !byp_take;
    assign pop_vld  = fifo_vld && inst_ready_i && !redirect_i;

    fq_fifo #(.W(64), .DEPTH(DEPTH)) u_inst_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push_vld (push_vld),
        .push_dat ({imem_rdata_i, resp_pc4}),
        .pop_vld  (pop_vld),
        .head_dat (head_dat)
    );

    // When empty the outputs hold the last consumed head rather than whatever
    // stale slot the read pointer now points at.
    assign inst_valid_o          = fifo_vld || byp_vld;
    assign {inst_o, pc_plus4_o}  = fifo_vld ? head_dat :
                                   byp_vld  ? {imem_rdata_i, resp_pc4} :
                                              last_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            occ      <= '0;
            osd      <= '0;
            dsc      <= '0;
            last_dat <= '0;
        end else begin
            // issue is already 0 during a redirect, so this covers both cases.
            osd <= osd + CW'(issue) - CW'(imem_rvalid_i);

            if (pop_vld)       last_dat <= head_dat;
            else if (byp_take) last_dat <= {imem_rdata_i, resp_pc4};

            if (redirect_i) begin
                fetch_pc <= redirect_pc_i & ~32'h3;
                occ      <= '0;
                // Everything still in flight is from the old path.
                dsc      <= osd - CW'(imem_rvalid_i);
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                occ <= occ + CW'(push_vld) - CW'(pop_vld);
                if (imem_rvalid_i && (dsc != '0)) dsc <= dsc - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order memory model.
// Latency: checks both the registered path and, when built with FQ_BYPASS_EN, the 0-cycle path.
// Backpressure: exercises consumer stalls, credit exhaustion and redirect discards.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_plus4_o;
    logic        inst_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];

    logic        s_req, s_vld;
    logic [31:0] s_addr, s_inst, s_pc4;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_plus4_o    (pc_plus4_o),
        .inst_ready_i  (inst_ready_i)
    );

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    task automatic mem_drive();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = pend_addr[0] ^ 32'hA5A5_0000;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
        end
    endtask

    // Sample the current cycle at the falling edge, then advance past the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_req  = imem_req_o;
        s_addr = imem_addr_o;
        s_vld  = inst_valid_o;
        s_inst = inst_o;
        s_pc4  = pc_plus4_o;
        if (imem_req_o && imem_gnt_i) begin
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", imem_req_o); end
        n_checks++;
        if (imem_addr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_addr: got %h want 00003000", imem_addr_o); end
        n_checks++;
        if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        n_checks++;
        if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        n_checks++;
        if (pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", pc_plus4_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        lat = 1; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            exp = 32'h3000 + 32'(4 * k);
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== exp) begin
                n_fail++; $display("FAIL stream_addr k=%0d: req=%b addr=%h want req=1 addr=%h", k, s_req, s_addr, exp);
            end
            if (k >= 2 - BYP) begin
                exp = 32'h3000 + 32'(4 * (k - 1 + BYP));
                n_checks++;
                if (s_vld !== 1'b1 || s_pc4 !== exp || s_inst !== ((exp - 32'd4) ^ 32'hA5A5_0000)) begin
                    n_fail++; $display("FAIL stream_data k=%0d: vld=%b pc4=%h inst=%h want vld=1 pc4=%h", k, s_vld, s_pc4, s_inst, exp);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int grants;
        logic [31:0] exp;
        do_reset();
        n_checks++;
        if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h3000) begin
            n_fail++; $display("FAIL midop_reset: vld=%b req=%b addr=%h want 0 1 00003000", inst_valid_o, imem_req_o, imem_addr_o);
        end
        lat = 1; imem_gnt_i = 1'b1; inst_ready_i = 1'b0; grants = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_req) grants++;
        end
        n_checks++;
        if (grants !== DEPTH) begin n_fail++; $display("FAIL stall_grants: got %0d want %0d", grants, DEPTH); end
        n_checks++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", s_req); end
        n_checks++;
        if (s_vld !== 1'b1 || s_pc4 !== 32'h3004) begin
            n_fail++; $display("FAIL stall_head: vld=%b pc4=%h want 1 00003004", s_vld, s_pc4);
        end
        inst_ready_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cycle();
            exp = 32'h3004 + 32'(4 * j);
            n_checks++;
            if (s_vld !== 1'b1 || s_pc4 !== exp || s_inst !== ((exp - 32'd4) ^ 32'hA5A5_0000)) begin
                n_fail++; $display("FAIL drain j=%0d: vld=%b pc4=%h inst=%h want vld=1 pc4=%h", j, s_vld, s_pc4, s_inst, exp);
            end
            if (j == 0) begin
                n_checks++;
                if (s_req !== 1'b0) begin n_fail++; $display("FAIL drain_full_req: got %b want 0", s_req); end
            end
            if (j == 1) begin
                n_checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h3010) begin
                    n_fail++; $display("FAIL resume: req=%b addr=%h want 1 00003010", s_req, s_addr);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int first;
        logic [31:0] exp;
        do_reset();
        lat = 3; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        cycle();
        cycle();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_3103;
        cycle();
        n_checks++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", s_req); end
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        first = 7 - BYP;
        for (int k = 3; k < 9; k++) begin
            cycle();
            if (k == 3) begin
                n_checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h3100) begin
                    n_fail++; $display("FAIL redir_addr: req=%b addr=%h want 1 00003100", s_req, s_addr);
                end
            end
            n_checks++;
            if (k < first) begin
                if (s_vld !== 1'b0) begin n_fail++; $display("FAIL redir_stale k=%0d: vld=%b pc4=%h want vld=0", k, s_vld, s_pc4); end
            end else begin
                exp = 32'h3104 + 32'(4 * (k - first));
                if (s_vld !== 1'b1 || s_pc4 !== exp || s_inst !== ((exp - 32'd4) ^ 32'hA5A5_0000)) begin
                    n_fail++; $display("FAIL redir_data k=%0d: vld=%b pc4=%h inst=%h want vld=1 pc4=%h", k, s_vld, s_pc4, s_inst, exp);
                end
            end
        end
    endtask

    task automatic test_redirect_rvalid();
        int first;
        logic [31:0] exp;
        do_reset();
        lat = 2; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        cycle();
        imem_gnt_i = 1'b0;
        cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_3200;
        cycle();
        n_checks++;
        if (s_req !== 1'b0 || s_vld !== 1'b0) begin
            n_fail++; $display("FAIL rr_cycle: req=%b vld=%b want 0 0", s_req, s_vld);
        end
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        first = 6 - BYP;
        for (int k = 3; k < 8; k++) begin
            cycle();
            if (k == 3) begin
                n_checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h3200) begin
                    n_fail++; $display("FAIL rr_addr: req=%b addr=%h want 1 00003200", s_req, s_addr);
                end
            end
            n_checks++;
            if (k < first) begin
                if (s_vld !== 1'b0) begin n_fail++; $display("FAIL rr_stale k=%0d: vld=%b pc4=%h want vld=0", k, s_vld, s_pc4); end
            end else begin
                exp = 32'h3204 + 32'(4 * (k - first));
                if (s_vld !== 1'b1 || s_pc4 !== exp) begin
                    n_fail++; $display("FAIL rr_data k=%0d: vld=%b pc4=%h want vld=1 pc4=%h", k, s_vld, s_pc4, exp);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int first;
        logic [31:0] exp;
        do_reset();
        lat = 1; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        redirect_i = 1'b0;
        first = 3 - BYP;
        for (int k = 1; k < 6; k++) begin
            cycle();
            if (k == 1) begin
                n_checks++;
                if (s_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", s_addr); end
            end
            if (k == 2) begin
                n_checks++;
                if (s_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", s_addr); end
            end
            if (k >= first) begin
                exp = 32'(4 * (k - first));
                n_checks++;
                if (s_vld !== 1'b1 || s_pc4 !== exp || s_inst !== ((exp - 32'd4) ^ 32'hA5A5_0000)) begin
                    n_fail++; $display("FAIL wrap_data k=%0d: vld=%b pc4=%h inst=%h want vld=1 pc4=%h", k, s_vld, s_pc4, s_inst, exp);
                end
            end
        end
    endtask

    task automatic test_bypass();
`ifdef FQ_BYPASS_EN
        do_reset();
        lat = 1; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
        cycle();
        imem_gnt_i   = 1'b0;
        imem_rdata_i = 32'h2408_0001;
        cycle();
        n_checks++;
        if (s_vld !== 1'b1 || s_inst !== 32'h2408_0001 || s_pc4 !== 32'h3004) begin
            n_fail++; $display("FAIL bypass: vld=%b inst=%h pc4=%h want 1 24080001 00003004", s_vld, s_inst, s_pc4);
        end
        cycle();
        n_checks++;
        if (s_vld !== 1'b0) begin n_fail++; $display("FAIL bypass_consumed: vld=%b want 0", s_vld); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

In-order instruction prefetch queue between a handshaked instruction memory port and the IF/ID pipeline register of the pipelined MIPS core. It generates sequential fetch addresses, keeps up to DEPTH instructions outstanding or buffered, and presents them with their PC+4 to the decode side. Branch and jump redirects flush the queue and discard stale in-flight responses, so the memory can have a variable latency.

## Interface
- DEPTH, 4, queue entries and the maximum in-flight plus buffered count; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_3000, fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (rst==0 resets).
- redirect_i  in  1  taken branch or jump; flushes the queue.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored and treated as 0.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word address of the request.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in request order.
- imem_rdata_i  in  32  instruction word.
- inst_valid_o  out  1  head entry valid.
- inst_o  out  32  head instruction.
- pc_plus4_o  out  32  head PC + 4, feeding IFIDPCPlus4.
- inst_ready_i  in  1  consumer accepts the head entry; driven as !IFIDStall.

## Operation
- State: fetch_pc, FIFO of {inst, pc_plus4}, occupancy count occ, outstanding count osd, discard count dsc, and a PC tag FIFO for outstanding requests. The counters are log2(DEPTH)+1 bits wide.
- Issue: imem_req_o = !redirect_i && (occ + osd < DEPTH). imem_addr_o = fetch_pc.
  - On req && gnt: fetch_pc += 4 (wraps 0xFFFF_FFFC to 0x0000_0000), osd++, and the PC is pushed to the tag FIFO.
  - Address and request stay stable until granted, unless a redirect occurs.
- Response: on rvalid_i, osd-- and the tag is popped.
  - If dsc > 0, the response is dropped and dsc--.
  - Otherwise {rdata, tag+4} is pushed into the FIFO.
- Pop: on inst_valid_o && inst_ready_i, occ--. Push and pop in the same cycle leave occ unchanged.
- Redirect (priority over push, pop and issue in that cycle):
  - FIFO is cleared (occ = 0).
  - fetch_pc = redirect_pc_i.
  - dsc = osd, minus 1 if a response arrives in the same cycle (that response is dropped).
  - imem_req_o = 0 in that cycle; a grant seen in that cycle is a protocol violation.
- Issue is gated while dsc > 0 only through the credit rule occ + osd < DEPTH.
- Full condition: occ + osd == DEPTH. No request issues; responses still land, because credit was reserved at issue.
- Empty condition: inst_valid_o = 0 and inst_o / pc_plus4_o hold the last head value (don't-care for the consumer).

## Timing
- Reset values:
  - fetch_pc = RESET_PC.
  - occ = osd = dsc = 0.
  - imem_req_o = 1 (combinational, from credit) and imem_addr_o = RESET_PC.
  - inst_valid_o = 0, inst_o = 0, pc_plus4_o = 0.
- Reset mid-operation discards all state immediately. The memory is reset by the same rst, so no stale responses arrive.
- Latency: rvalid in cycle N gives inst_valid_o in cycle N+1.
- Throughput: 1 instruction per cycle when gnt is held at 1 and memory latency ≤ DEPTH-1 cycles.
- Redirect in cycle N: the first request to the new PC issues in cycle N+1. Its instruction is valid no earlier than cycle N+3 with 1-cycle memory latency.

## Configuration
- FQ_BYPASS_EN defined:
  - When occ == 0, dsc == 0, no redirect, and rvalid_i == 1, the response drives inst_o / pc_plus4_o / inst_valid_o combinationally in the same cycle.
  - If inst_ready_i == 1 the entry is consumed and not pushed; otherwise it is pushed.
  - Latency becomes 0 cycles.
- FQ_BYPASS_EN undefined: all responses pass through the FIFO with 1-cycle latency; outputs are purely registered-state driven.

## Test plan
- Reset, then gnt = 1 and 1-cycle rvalid with rdata = addr ^ 32'hA5A5_0000, ready = 1 → addresses 0x3000, 0x3004, …; pc_plus4_o = 0x3004, 0x3008, … at 1 instruction per cycle with no gaps.
- ready = 0 for 10 cycles → exactly DEPTH (4) requests are granted, then imem_req_o = 0. Releasing ready drains 4 entries in order, then fetching resumes.
- Memory latency 3 with 2 requests outstanding, redirect_pc_i = 0x3100 → both stale responses are dropped, the next request address is 0x3100, and the first pc_plus4_o is 0x3104.
- Redirect in the same cycle as rvalid with 1 outstanding → the response is dropped, dsc stays 0, and the next valid entry comes from the new PC.
- fetch_pc = 0xFFFF_FFFC → the next request address is 0x0000_0000, and pc_plus4_o of the wrapped entry is 0x0000_0000.
- Under FQ_BYPASS_EN, empty queue, rvalid with rdata = 0x2408_0001 and ready = 1 → inst_valid_o = 1 and inst_o = 0x2408_0001 in the same cycle, and occ stays 0.
